// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: one queued write is an
// (address, data) pair targeting the 16x16 register file.
package wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic logic addr_hit(input wb_entry_t entry, input logic [REG_ADDR_W-1:0] addr);
    return (entry.addr == addr);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes: up to two pushes and one pop
// per cycle, with the whole array and an occupancy mask exposed for hazard compare.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_a_i,
  input  logic [ENTRY_W-1:0]              entry_a_i,
  input  logic                            push_b_i,
  input  logic [ENTRY_W-1:0]              entry_b_i,
  input  logic                            pop_i,
  output logic [ENTRY_W-1:0]              head_o,
  output logic [DEPTH-1:0][ENTRY_W-1:0]   entries_o,
  output logic [DEPTH-1:0]                valid_o,
  output logic [CNT_W-1:0]                count_o
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      slot_b_s;
  logic [PTR_W-1:0]      off_s;

  // Next-state: entry B is always the younger one and lands just after entry A.
  always_comb begin
    mem_d           = mem_q;
    slot_b_s        = wr_ptr_q + PTR_W'(push_a_i);
    mem_d[wr_ptr_q] = push_a_i ? wb_entry_t'(entry_a_i) : mem_q[wr_ptr_q];
    if (push_b_i) begin
      mem_d[slot_b_s] = wb_entry_t'(entry_b_i);
    end else begin
      mem_d[slot_b_s] = mem_d[slot_b_s];
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
  end

  // Storage, pointers and occupancy; all cleared on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot i is occupied when its distance from the read pointer is below the count.
  always_comb begin
    off_s   = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = (CNT_W'(off_s) < count_q);
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign count_o   = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register-file writer: merges load and ALU results into an in-order queue,
// retires one write per cycle, and flags addresses with writes still pending.
module regfile_writeback_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = REG_ADDR_W,
  parameter  int DATA_W = REG_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              wb_hold_i,
  output logic              write_en_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] data_write_o,
  input  logic [ADDR_W-1:0] chk_addr_a_i,
  input  logic [ADDR_W-1:0] chk_addr_b_i,
  output logic              pending_a_o,
  output logic              pending_b_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ROOM2_C = CNT_W'(DEPTH - 2);

  wb_entry_t             mem_entry_s, alu_entry_s, entry_a_s, head_s;
  wb_entry_t [DEPTH-1:0] entries_s;
  logic [DEPTH-1:0]      valid_s;
  logic [CNT_W-1:0]      count_s;
  logic                  mem_push_s, alu_push_s;
  logic                  push_a_s, push_b_s, pop_s, nonempty_s;

  assign mem_entry_s = '{addr: mem_addr_i, data: mem_data_i};
  assign alu_entry_s = '{addr: alu_addr_i, data: alu_data_i};

  // Acceptance uses registered occupancy only; a valid load reserves a slot ahead of the ALU.
  always_comb begin
    nonempty_s  = (count_s != '0);
    mem_ready_o = rst_ni & (count_s < FULL_C);
    if (mem_valid_i) begin
      alu_ready_o = rst_ni & (count_s <= ROOM2_C);
    end else begin
      alu_ready_o = rst_ni & (count_s < FULL_C);
    end
    mem_push_s = mem_valid_i & mem_ready_o;
    alu_push_s = alu_valid_i & alu_ready_o;
    push_a_s   = mem_push_s | alu_push_s;
    push_b_s   = mem_push_s & alu_push_s;
    if (mem_push_s) begin
      entry_a_s = mem_entry_s;
    end else begin
      entry_a_s = alu_entry_s;
    end
    pop_s = nonempty_s & ~wb_hold_i;
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_a_i  (push_a_s),
    .entry_a_i (entry_a_s),
    .push_b_i  (push_b_s),
    .entry_b_i (alu_entry_s),
    .pop_i     (pop_s),
    .head_o    (head_s),
    .entries_o (entries_s),
    .valid_o   (valid_s),
    .count_o   (count_s)
  );

  // Write port shows the head whenever the queue is non-empty; pending includes the retiring head.
  always_comb begin
    write_en_o = pop_s;
    if (nonempty_s) begin
      write_addr_o = head_s.addr;
      data_write_o = head_s.data;
    end else begin
      write_addr_o = {ADDR_W{1'b0}};
      data_write_o = {DATA_W{1'b0}};
    end
    pending_a_o = 1'b0;
    pending_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_a_o = pending_a_o | (valid_s[i] & addr_hit(entries_s[i], chk_addr_a_i));
      pending_b_o = pending_b_o | (valid_s[i] & addr_hit(entries_s[i], chk_addr_b_i));
    end
  end

  assign count_o = count_s;

endmodule
